piso_tx: RTL

Parallel-in serial-out transmitter: the sending end of the lab serial shift-register chain. It accepts a parallel word through a valid/ready handshake and drives it onto a single-bit line, one bit per clock, with a valid and a last-bit marker. Its output feeds a serial shift chain or a serial-to-parallel receiver directly. It supports back-to-back words with no idle gap.

---
 rtl/piso_tx_pkg.sv | 11 +
 rtl/piso_tx_bit_counter.sv | 33 +++
 rtl/piso_tx.sv | 80 ++++++++
 3 files changed

// File: rtl/piso_tx_pkg.sv
// Shared definitions for the serial shift-register chain blocks.
package piso_tx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_tx_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and terminal-count flag.
module bit_counter
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: valid/ready word in, one registered bit per clock out.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             out_valid,
    output logic             last
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             last_q, last_d;
    logic             tc;
    logic             accept;
    logic             cur_bit;

    assign ready   = (state_q == IDLE) || ((state_q == SHIFT) && tc);
    assign accept  = load && ready;
    assign cur_bit = LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1];

    bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk(clk),
        .clr(rst || accept),
        .en (state_q == SHIFT),
        .tc (tc)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        if (accept) begin
            state_d = SHIFT;
            shift_d = din;
        end else if (state_q == SHIFT) begin
            shift_d = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
            if (tc) begin
                state_d = IDLE;
            end
        end
        // Outputs lag state/count by one cycle so the line is driven from flops.
        out_d       = (state_q == SHIFT) && cur_bit;
        out_valid_d = (state_q == SHIFT);
        last_d      = (state_q == SHIFT) && tc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign last      = last_q;

endmodule
